// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU and result bus of the sequential ALU issuing controller.
// The slave modport is the controller's view; the master modport is its environment.
interface alu_issue_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             instr_valid;
  logic             instr_ready;
  logic [9:0]       instr;
  logic [3:0]       alu_A;
  logic [3:0]       alu_B;
  logic [3:0]       alu_sel;
  logic [3:0]       alu_C;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_data;
  logic [1:0]       res_rd;
  logic             res_err;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  instr_valid, instr, alu_C, res_ready,
    output instr_ready, alu_A, alu_B, alu_sel, res_valid, res_data, res_rd, res_err, retired
  );

  modport master (
    output instr_valid, instr, alu_C, res_ready,
    input  instr_ready, alu_A, alu_B, alu_sel, res_valid, res_data, res_rd, res_err, retired
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Serialising issue controller for the 4-bit ALU: IDLE accepts and reads operands,
// EXEC writes back the ALU (or immediate) result, RESP presents it until consumed.
module alu_issue_ctrl #(
  parameter int NREG  = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [3:0]       OP_ALU_LAST = 4'b1000;
  localparam logic [3:0]       OP_LDI      = 4'b1001;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       rf_q [NREG];
  logic [3:0]       alu_a_q;
  logic [3:0]       alu_b_q;
  logic [3:0]       alu_sel_q;
  logic [1:0]       rd_q;
  logic [3:0]       imm_q;
  logic             instr_ready_q;
  logic             res_valid_q;
  logic [3:0]       res_data_q;
  logic [1:0]       res_rd_q;
  logic             res_err_q;
  logic [CNT_W-1:0] retired_q;

  logic [3:0]       res_data_d;
  logic             res_err_d;
  logic             wr_en_d;

  // Decode of the instruction sitting in EXEC; alu_sel_q doubles as the latched opcode.
  always_comb begin
    res_data_d = 4'h0;
    res_err_d  = 1'b0;
    wr_en_d    = 1'b0;
    if (alu_sel_q <= OP_ALU_LAST) begin
      res_data_d = bus.alu_C;
      wr_en_d    = 1'b1;
    end else if (alu_sel_q == OP_LDI) begin
      res_data_d = imm_q;
      wr_en_d    = 1'b1;
    end else begin
      res_err_d  = 1'b1;
    end
  end

  // Controller state, register file and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= 4'h0;
      end
      alu_a_q       <= 4'h0;
      alu_b_q       <= 4'h0;
      alu_sel_q     <= 4'h0;
      rd_q          <= 2'd0;
      imm_q         <= 4'h0;
      instr_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      res_data_q    <= 4'h0;
      res_rd_q      <= 2'd0;
      res_err_q     <= 1'b0;
      retired_q     <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.instr_valid) begin
            // Operands are read here, so rd may alias rs1/rs2 and still see the old value.
            alu_sel_q     <= bus.instr[9:6];
            rd_q          <= bus.instr[5:4];
            imm_q         <= bus.instr[3:0];
            alu_a_q       <= rf_q[bus.instr[3:2]];
            alu_b_q       <= rf_q[bus.instr[1:0]];
            instr_ready_q <= 1'b0;
            state_q       <= EXEC;
          end else begin
            state_q       <= IDLE;
          end
        end
        EXEC: begin
          if (wr_en_d) begin
            rf_q[rd_q] <= res_data_d;
          end else begin
            rf_q[rd_q] <= rf_q[rd_q];
          end
          res_data_q  <= res_data_d;
          res_err_q   <= res_err_d;
          res_rd_q    <= rd_q;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            instr_ready_q <= 1'b1;
            retired_q     <= retired_q + CNT_ONE;
            state_q       <= IDLE;
          end else begin
            state_q       <= RESP;
          end
        end
        default: begin
          res_valid_q   <= 1'b0;
          instr_ready_q <= 1'b1;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.alu_A       = alu_a_q;
  assign bus.alu_B       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_rd      = res_rd_q;
  assign bus.res_err     = res_err_q;
  assign bus.retired     = retired_q;
endmodule
